// File: rtl/arb_req_queue_pkg.sv
// rtl/arb_req_queue_pkg.sv - shared state encoding for the arbiter request front-end
//
// Purpose: FSM state type used by arb_req_queue. The encodings are fixed so that
// other bus-side blocks decoding the request state agree on them.
// Ports: none (package).

package arb_req_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_RSVD = 2'd3   // unreachable; recovers to ST_IDLE
  } arb_state_t;

endpackage : arb_req_queue_pkg

// File: rtl/arb_req_queue_sync_fifo.sv
// rtl/arb_req_queue_sync_fifo.sv - single-clock FIFO with occupancy count and head view
//
// Purpose: circular-buffer FIFO. Also reused by the downstream bus mux.
// Ports:
//   clk      in   clock, all state on posedge
//   reset    in   synchronous active-high flush
//   i_push   in   write i_data (ignored while full)
//   i_pop    in   drop head entry (ignored while empty)
//   i_data   in   WIDTH write data
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
//   o_count  out  occupancy, $clog2(DEPTH+1) bits
//   o_head   out  head entry, 0 when empty

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A push is refused whenever full, even alongside a pop; the full flag
  // is what the client sees as in_ready, so it must not depend on i_pop.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain AW-bit overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule : sync_fifo

// File: rtl/arb_req_queue.sv
// rtl/arb_req_queue.sv - per-client request queue feeding one side of the two-way arbiter
//
// Purpose: buffers client command words, requests the arbiter while work is
// pending, and streams at most BURST_MAX words per grant onto the shared bus.
// req always drops for at least one cycle after each burst.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high; aborts any burst and flushes
//   in_valid   in   client word offered
//   in_ready   out  FIFO not full; push = in_valid & in_ready
//   in_data    in   WIDTH client word
//   req        out  request to arbiter (state != IDLE)
//   grant      in   grant from arbiter
//   out_valid  out  bus word valid (XFER and grant); no backpressure
//   out_data   out  FIFO head, 0 when empty
//   out_last   out  final word of the current burst
//   count      out  FIFO occupancy

module arb_req_queue
  import arb_req_queue_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       req,
  input  logic                       grant,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(BURST_MAX+1);
  localparam logic [CW-1:0] BURST_C = CW'(BURST_MAX);
  localparam logic [BW-1:0] BEATS_C = BW'(BURST_MAX);

  arb_state_t    r_state;
  logic [BW-1:0] r_beats;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic [BW-1:0] w_beats_init;

  assign w_push   = in_valid & ~w_full;
  assign w_pop    = (r_state == ST_XFER) & grant;

  assign in_ready  = ~w_full;
  assign count     = w_count;
  assign req       = (r_state != ST_IDLE);
  assign out_valid = w_pop;
  assign out_last  = w_pop & (r_beats == BW'(1));

  // Burst length is frozen from the pre-push occupancy at the grant edge;
  // words arriving later wait for the next burst. count <= BURST_MAX fits in BW.
  assign w_beats_init = (w_count >= BURST_C) ? BEATS_C : BW'(w_count);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (out_data)
  );

  // REQ is only entered with a non-empty FIFO and nothing pops during REQ,
  // so the latched beat count is never zero. A missing grant in XFER simply
  // holds state and beats until the arbiter returns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_beats <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_REQ;
        end
        ST_REQ: begin
          if (grant) begin
            r_state <= ST_XFER;
            r_beats <= w_beats_init;
          end
        end
        ST_XFER: begin
          if (grant) begin
            r_beats <= r_beats - 1'b1;
            if (r_beats == BW'(1)) r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_beats <= '0;
        end
      endcase
    end
  end

endmodule : arb_req_queue
